// File: rtl/transpose_ctrl_if.sv
// Bus bundle for the transpose sequencer: host request and status, matrix storage
// read/write ports, and the level-enabled transpose unit.
interface transpose_ctrl_if #(
    parameter int DATA_WIDTH = 9,
    parameter int ID_W       = 3
);
    logic                      start;
    logic [ID_W-1:0]           src_id;
    logic [ID_W-1:0]           dst_id;
    logic [2:0]                r_in;
    logic [2:0]                c_in;

    logic                      rd_en;
    logic [ID_W-1:0]           rd_id;
    logic [4:0]                rd_idx;
    logic [DATA_WIDTH-1:0]     rd_data;

    logic                      tr_en;
    logic [2:0]                tr_r;
    logic [2:0]                tr_c;
    logic [25*DATA_WIDTH-1:0]  tr_data;
    logic [25*DATA_WIDTH-1:0]  tr_q;
    logic [2:0]                tr_r_q;
    logic [2:0]                tr_c_q;

    logic                      wr_en;
    logic [ID_W-1:0]           wr_id;
    logic [4:0]                wr_idx;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      wr_dim_en;
    logic [2:0]                wr_r;
    logic [2:0]                wr_c;

    logic                      busy;
    logic                      done;
    logic                      err;

    // master: host, storage and transpose unit side; slave: the sequencer
    modport master (
        output start, src_id, dst_id, r_in, c_in, rd_data, tr_q, tr_r_q, tr_c_q,
        input  rd_en, rd_id, rd_idx, tr_en, tr_r, tr_c, tr_data,
               wr_en, wr_id, wr_idx, wr_data, wr_dim_en, wr_r, wr_c, busy, done, err
    );

    modport slave (
        input  start, src_id, dst_id, r_in, c_in, rd_data, tr_q, tr_r_q, tr_c_q,
        output rd_en, rd_id, rd_idx, tr_en, tr_r, tr_c, tr_data,
               wr_en, wr_id, wr_idx, wr_data, wr_dim_en, wr_r, wr_c, busy, done, err
    );
endinterface

// File: rtl/transpose_ctrl.sv
// Sequencer for the 5x5 transpose datapath: buffer the source matrix, arm the
// transpose unit, let it settle, then write the result and swapped dimensions.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; illegal dimensions raise err next cycle
// S_LOAD   | 25 reads (cnt 0..24) plus one cycle to catch the last datum
// S_ARM    | tr_en rises with the complete operand buffer
// S_SETTLE | SETTLE_CYC cycles of tr_en high, down-counter tmr
// S_STORE  | 25 writes of tr_q, dimensions written on the first
// S_DONE   | tr_en low, done pulse
module transpose_ctrl #(
    parameter int DATA_WIDTH = 9,
    parameter int ID_W       = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    transpose_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_SETTLE, S_STORE, S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [4:0]               cnt, cnt_nxt;
    logic [3:0]               tmr, tmr_nxt;
    logic                     err_q, err_nxt;
    logic                     cap;
    logic                     dims_ok;
    logic [ID_W-1:0]          src_q, dst_q;
    logic [2:0]               r_q, c_q;
    logic [25*DATA_WIDTH-1:0] op_buf;

    assign dims_ok = (bus.r_in != 3'd0) && (bus.r_in <= 3'd5) &&
                     (bus.c_in != 3'd0) && (bus.c_in <= 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            tmr   <= '0;
            err_q <= 1'b0;
            src_q <= '0;
            dst_q <= '0;
            r_q   <= '0;
            c_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tmr   <= tmr_nxt;
            err_q <= err_nxt;
            if (cap) begin
                src_q <= bus.src_id;
                dst_q <= bus.dst_id;
                r_q   <= bus.r_in;
                c_q   <= bus.c_in;
            end
        end
    end

    // Read data lags the strobe by one cycle, so entry cnt-1 lands while cnt is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_buf <= '0;
        end else if (state == S_LOAD && cnt != 5'd0) begin
            op_buf[(int'(cnt) - 1) * DATA_WIDTH +: DATA_WIDTH] <= bus.rd_data;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        tmr_nxt       = tmr;
        err_nxt       = 1'b0;
        cap           = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_idx    = '0;
        bus.tr_en     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_data   = '0;
        bus.wr_dim_en = 1'b0;
        bus.wr_r      = '0;
        bus.wr_c      = '0;
        bus.done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    cap = 1'b1;
                    if (dims_ok) begin
                        state_nxt = S_LOAD;
                        cnt_nxt   = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (cnt != 5'd25) begin
                    bus.rd_en  = 1'b1;
                    bus.rd_idx = cnt;
                    cnt_nxt    = cnt + 5'd1;
                end else begin
                    state_nxt = S_ARM;
                    cnt_nxt   = '0;
                end
            end
            S_ARM: begin
                bus.tr_en = 1'b1;
                tmr_nxt   = 4'(SETTLE_CYC - 1);
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                bus.tr_en = 1'b1;
                if (tmr == 4'd0) state_nxt = S_STORE;
                else             tmr_nxt   = tmr - 4'd1;
            end
            S_STORE: begin
                bus.tr_en   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_idx  = cnt;
                bus.wr_data = bus.tr_q[int'(cnt) * DATA_WIDTH +: DATA_WIDTH];
                if (cnt == 5'd0) begin
                    bus.wr_dim_en = 1'b1;
                    bus.wr_r      = bus.tr_r_q;
                    bus.wr_c      = bus.tr_c_q;
                end
                if (cnt == 5'd24) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 5'd1;
                end
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.rd_id   = src_q;
    assign bus.wr_id   = dst_q;
    assign bus.tr_r    = r_q;
    assign bus.tr_c    = c_q;
    assign bus.tr_data = op_buf;
    assign bus.busy    = (state != S_IDLE);
    assign bus.err     = err_q;
endmodule

// File: tb/tb_transpose_ctrl.sv
// Bench for transpose_ctrl: two instances (SETTLE_CYC 2 and 5) with storage and
// transpose-unit models, an operation-timeline reference model and directed tests.
`timescale 1ns/1ps
module tb_transpose_ctrl;
    localparam int DW = 9;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] mem   [2][8][25];
    logic [2:0]    dim_r [2][8];
    logic [2:0]    dim_c [2][8];

    logic          start_v [2];
    logic [IW-1:0] src_v   [2];
    logic [IW-1:0] dst_v   [2];
    logic [2:0]    r_v     [2];
    logic [2:0]    c_v     [2];
    logic          done_v  [2];
    logic          busy_v  [2];
    logic          wr_en_v [2];
    logic [4:0]    wr_idx_v[2];

    int n_rd[2], n_wr[2], n_done[2], n_err[2], n_tr[2], min_gap[2];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int S = (g == 0) ? 2 : 5;

        transpose_ctrl_if #(.DATA_WIDTH(DW), .ID_W(IW)) bus ();
        transpose_ctrl #(.DATA_WIDTH(DW), .ID_W(IW), .SETTLE_CYC(S)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );

        assign bus.start    = start_v[g];
        assign bus.src_id   = src_v[g];
        assign bus.dst_id   = dst_v[g];
        assign bus.r_in     = r_v[g];
        assign bus.c_in     = c_v[g];
        assign done_v[g]    = bus.done;
        assign busy_v[g]    = bus.busy;
        assign wr_en_v[g]   = bus.wr_en;
        assign wr_idx_v[g]  = bus.wr_idx;

        // Level-enabled transpose unit.
        always_comb begin
            bus.tr_q   = '0;
            bus.tr_r_q = '0;
            bus.tr_c_q = '0;
            if (bus.tr_en) begin
                bus.tr_r_q = bus.tr_c;
                bus.tr_c_q = bus.tr_r;
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        if (i < int'(bus.tr_r) && j < int'(bus.tr_c))
                            bus.tr_q[(j*5+i)*DW +: DW] = bus.tr_data[(i*5+j)*DW +: DW];
            end
        end

        // Storage: one-cycle read latency, writes land on the clock edge.
        logic          p_rd, p_wr, p_dim;
        logic [IW-1:0] p_rid, p_wid;
        logic [4:0]    p_ridx, p_widx;
        logic [DW-1:0] p_wdata;
        logic [2:0]    p_r, p_c;
        initial begin
            bus.rd_data = '1;
            forever begin
                @(negedge clk);
                p_rd = bus.rd_en;  p_rid = bus.rd_id;  p_ridx = bus.rd_idx;
                p_wr = bus.wr_en;  p_wid = bus.wr_id;  p_widx = bus.wr_idx;
                p_wdata = bus.wr_data; p_dim = bus.wr_dim_en; p_r = bus.wr_r; p_c = bus.wr_c;
                @(posedge clk);
                #1;
                bus.rd_data = p_rd ? mem[g][p_rid][p_ridx] : '1;
                if (rst_n && p_wr)  mem[g][p_wid][p_widx] = p_wdata;
                if (rst_n && p_dim) begin
                    dim_r[g][p_wid] = p_r;
                    dim_c[g][p_wid] = p_c;
                end
            end
        end

        // Reference model: mt = cycles since the accepted start (0 = idle).
        int            mt = 0;
        logic          errx = 1'b0;
        int            mr = 0, mc = 0;
        logic [IW-1:0] msrc = '0, mdst = '0;
        logic [DW-1:0] snap [25];
        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    mt   = 0;
                    errx = 1'b0;
                end else begin
                    errx = 1'b0;
                    if (mt > 0) begin
                        mt = (mt == 53 + S) ? 0 : mt + 1;
                    end else if (start_v[g]) begin
                        if (r_v[g] >= 3'd1 && r_v[g] <= 3'd5 && c_v[g] >= 3'd1 && c_v[g] <= 3'd5) begin
                            mt = 1;
                            mr = int'(r_v[g]);
                            mc = int'(c_v[g]);
                            msrc = src_v[g];
                            mdst = dst_v[g];
                            for (int k = 0; k < 25; k++) snap[k] = mem[g][src_v[g]][k];
                        end else begin
                            errx = 1'b1;
                        end
                    end
                end
            end
        end

        logic              exp_rd, exp_tr, exp_wr;
        logic [25*DW-1:0]  exp_data;
        logic [DW-1:0]     exp_w;
        int                w, a, b, low_run = 0;
        logic              seen_hi = 1'b0;
        initial begin
            forever begin
                @(negedge clk);
                exp_rd = (mt >= 1 && mt <= 25);
                exp_tr = (mt >= 27 && mt <= 52 + S);
                exp_wr = (mt >= 28 + S && mt <= 52 + S);
                chk("rd_en", bus.rd_en, exp_rd);
                if (exp_rd) begin
                    chk("rd_idx", bus.rd_idx, mt - 1);
                    chk("rd_id", bus.rd_id, msrc);
                end
                chk("tr_en", bus.tr_en, exp_tr);
                if (exp_tr) begin
                    exp_data = '0;
                    for (int k = 0; k < 25; k++) exp_data[k*DW +: DW] = snap[k];
                    chk("tr_data", bus.tr_data, exp_data);
                    chk("tr_r", bus.tr_r, mr);
                    chk("tr_c", bus.tr_c, mc);
                end
                chk("wr_en", bus.wr_en, exp_wr);
                if (exp_wr) begin
                    w = mt - 28 - S;
                    a = w / 5;
                    b = w % 5;
                    exp_w = (a < mc && b < mr) ? snap[b*5+a] : '0;
                    chk("wr_idx", bus.wr_idx, w);
                    chk("wr_id", bus.wr_id, mdst);
                    chk("wr_data", bus.wr_data, exp_w);
                end
                chk("wr_dim_en", bus.wr_dim_en, mt == 28 + S);
                if (mt == 28 + S) begin
                    chk("wr_r", bus.wr_r, mc);
                    chk("wr_c", bus.wr_c, mr);
                end
                chk("done", bus.done, mt == 53 + S);
                chk("busy", bus.busy, mt >= 1);
                chk("err", bus.err, errx);
                n_rd[g]   += int'(bus.rd_en);
                n_wr[g]   += int'(bus.wr_en);
                n_done[g] += int'(bus.done);
                n_err[g]  += int'(bus.err);
                n_tr[g]   += int'(bus.tr_en);
                if (bus.tr_en) begin
                    if (seen_hi && low_run > 0 && low_run < min_gap[g]) min_gap[g] = low_run;
                    low_run = 0;
                    seen_hi = 1'b1;
                end else begin
                    low_run++;
                end
            end
        end
    end

    task automatic check_reset_outs(input string tag);
        chk(tag, {g_u[0].bus.rd_en, g_u[0].bus.rd_id, g_u[0].bus.rd_idx, g_u[0].bus.tr_en,
                  g_u[0].bus.tr_r, g_u[0].bus.tr_c, g_u[0].bus.wr_en, g_u[0].bus.wr_id,
                  g_u[0].bus.wr_idx, g_u[0].bus.wr_data, g_u[0].bus.wr_dim_en, g_u[0].bus.wr_r,
                  g_u[0].bus.wr_c, g_u[0].bus.busy, g_u[0].bus.done, g_u[0].bus.err}, '0);
        chk({tag, "_tr_data"}, g_u[0].bus.tr_data, '0);
    endtask

    task automatic pulse_start(input int d, input int src, input int dst, input int r, input int c);
        @(posedge clk);
        #1;
        src_v[d] = IW'(src);
        dst_v[d] = IW'(dst);
        r_v[d]   = 3'(r);
        c_v[d]   = 3'(c);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
    endtask

    // Returns the cycle (start cycle = 0) in which done was seen; poke>0 re-asserts start then.
    task automatic run_op(input int d, input int src, input int dst, input int r, input int c,
                          input int poke, output int lat);
        pulse_start(d, src, dst, r, c);
        lat = 1;
        while (!done_v[d] && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke != 0 && lat == poke) begin
                src_v[d] = 3'd7; dst_v[d] = 3'd0; r_v[d] = 3'd1; c_v[d] = 3'd1;
                start_v[d] = 1'b1;
            end else begin
                start_v[d] = 1'b0;
            end
        end
        chk("done_seen", done_v[d], 1'b1);
    endtask

    int lat;
    int rd0, wr0, err0, tr0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; src_v[d] = '0; dst_v[d] = '0; r_v[d] = '0; c_v[d] = '0;
            n_rd[d] = 0; n_wr[d] = 0; n_done[d] = 0; n_err[d] = 0; n_tr[d] = 0; min_gap[d] = 1000;
            for (int s = 0; s < 8; s++) begin
                dim_r[d][s] = '0;
                dim_c[d][s] = '0;
                for (int k = 0; k < 25; k++) mem[d][s][k] = '0;
            end
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset_outs");
        rst_n = 1'b1;

        // 3x4 from slot 1 to slot 2, storage[k] = k+1 inside the matrix
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) mem[0][1][i*5+j] = DW'(i*5 + j + 1);
        run_op(0, 1, 2, 3, 4, 0, lat);
        chk("t1_latency", lat, 55);
        repeat (2) @(posedge clk);
        #2;
        chk("t1_wr_idx1", mem[0][2][1], 6);
        chk("t1_wr_idx5", mem[0][2][5], 2);
        chk("t1_wr_idx3", mem[0][2][3], 0);
        chk("t1_dim_r", dim_r[0][2], 4);
        chk("t1_dim_c", dim_c[0][2], 3);

        // Illegal dimensions
        rd0 = n_rd[0]; wr0 = n_wr[0]; err0 = n_err[0]; tr0 = n_tr[0];
        pulse_start(0, 1, 2, 0, 3);
        repeat (3) @(posedge clk);
        pulse_start(0, 1, 2, 3, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("ill_err_pulses", n_err[0] - err0, 2);
        chk("ill_reads", n_rd[0] - rd0, 0);
        chk("ill_writes", n_wr[0] - wr0, 0);
        chk("ill_tr_en", n_tr[0] - tr0, 0);

        // start while busy
        rd0 = n_rd[0]; wr0 = n_wr[0]; n_done[0] = 0;
        run_op(0, 1, 2, 3, 4, 10, lat);
        chk("busy_latency", lat, 55);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_reads", n_rd[0] - rd0, 25);
        chk("busy_writes", n_wr[0] - wr0, 25);
        chk("busy_dones", n_done[0], 1);

        // Back-to-back 5x5: identity then 0..24
        for (int k = 0; k < 25; k++) begin
            mem[0][3][k] = (k % 6 == 0) ? DW'(1) : DW'(0);
            mem[0][4][k] = DW'(k);
        end
        run_op(0, 3, 5, 5, 5, 0, lat);
        run_op(0, 4, 6, 5, 5, 0, lat);
        chk("b2b_latency", lat, 55);
        repeat (2) @(posedge clk);
        #2;
        chk("b2b_id0", mem[0][5][0], 1);
        chk("b2b_id6", mem[0][5][6], 1);
        chk("b2b_id1", mem[0][5][1], 0);
        chk("b2b_id24", mem[0][5][24], 1);
        chk("b2b_v1", mem[0][6][1], 5);
        chk("b2b_v5", mem[0][6][5], 1);
        chk("b2b_v7", mem[0][6][7], 11);
        chk("b2b_v24", mem[0][6][24], 24);
        chk("b2b_min_gap_ge2", min_gap[0] >= 2, 1'b1);

        // Reset during STORE idx 12
        for (int k = 0; k < 25; k++) mem[0][7][k] = 9'h1AA;
        pulse_start(0, 4, 7, 5, 5);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (wr_en_v[0] && wr_idx_v[0] == 5'd12) break;
        end
        chk("mid_reached_idx12", {wr_en_v[0], wr_idx_v[0]}, {1'b1, 5'd12});
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid_reset_outs");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_idx11_written", mem[0][7][11], 7);
        chk("mid_idx12_kept", mem[0][7][12], 9'h1AA);
        chk("mid_idx24_kept", mem[0][7][24], 9'h1AA);
        chk("mid_idle_busy", busy_v[0], 1'b0);

        // SETTLE_CYC=5, in-place 2x5 in slot 3
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 5; j++) mem[1][3][i*5+j] = DW'(10 + i*5 + j);
        run_op(1, 3, 3, 2, 5, 0, lat);
        chk("s5_latency", lat, 58);
        repeat (2) @(posedge clk);
        #2;
        chk("s5_d0", mem[1][3][0], 10);
        chk("s5_d1", mem[1][3][1], 15);
        chk("s5_d2", mem[1][3][2], 0);
        chk("s5_d5", mem[1][3][5], 11);
        chk("s5_d6", mem[1][3][6], 16);
        chk("s5_d20", mem[1][3][20], 14);
        chk("s5_dim_r", dim_r[1][3], 5);
        chk("s5_dim_c", dim_c[1][3], 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/transpose_ctrl.md
Name: transpose_ctrl

Overview:
- Sequencer for the 5x5 matrix transpose datapath in the matrix calculator.
- Pipeline: fetches a source matrix element-by-element from matrix storage into a 25-entry operand buffer, then arms the level-enabled transpose unit. After a settle interval it writes the 25 transposed elements and the swapped dimensions to a destination slot.
- Guarantees the transpose enable is low between operations, so every operation is a fresh capture.

Parameters:
- DATA_WIDTH, 9, element width.
- ID_W, 3, matrix storage slot id width.
- SETTLE_CYC, 2, cycles tr_en is held high before result readout; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_id  in  ID_W  source slot; captured with start.
- dst_id  in  ID_W  destination slot; captured with start.
- r_in  in  3  source row count; captured with start.
- c_in  in  3  source column count; captured with start.
- rd_en  out  1  storage read strobe.
- rd_id  out  ID_W  read slot.
- rd_idx  out  5  read element index, row-major 0..24.
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
- tr_en  out  1  transpose enable.
- tr_r  out  3  rows to transpose unit.
- tr_c  out  3  columns to transpose unit.
- tr_data  out  25*DATA_WIDTH  flattened operand buffer; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- tr_q  in  25*DATA_WIDTH  flattened transpose result, same packing.
- tr_r_q  in  3  transposed row count.
- tr_c_q  in  3  transposed column count.
- wr_en  out  1  storage write strobe.
- wr_id  out  ID_W  write slot.
- wr_idx  out  5  write element index.
- wr_data  out  DATA_WIDTH  write data.
- wr_dim_en  out  1  dimension write strobe.
- wr_r  out  3  destination row count.
- wr_c  out  3  destination column count.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-dimension pulse.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including tr_en, rd_en, wr_en, wr_dim_en, done, err and busy.
  - Operand buffer and captured registers cleared.
  - Reset mid-operation aborts immediately. No further reads or writes are issued, and the partially written destination is left as-is.
- IDLE:
  - On start=1, capture src_id, dst_id, r_in and c_in.
  - If r_in or c_in is 0 or greater than 5: pulse err for 1 cycle next cycle and stay IDLE. No storage access.
  - Otherwise go to LOAD.
- LOAD, 26 cycles:
  - Cycles 1..25: rd_en=1, rd_id=src, rd_idx=0..24 incrementing.
  - Cycles 2..26: rd_data is written into buffer entry idx-1 (1-cycle read latency).
  - All 25 entries are fetched regardless of r/c. Storage returns 0 for unused positions.
- ARM, 1 cycle:
  - tr_en rises.
  - tr_r and tr_c carry the captured r and c; tr_data carries the full buffer.
  - tr_data, tr_r and tr_c are held stable from ARM until DONE.
- SETTLE, SETTLE_CYC cycles: tr_en=1, no other activity.
- STORE, 25 cycles:
  - tr_en stays 1.
  - wr_en=1, wr_id=dst, wr_idx=0..24, wr_data = element wr_idx of tr_q.
  - First STORE cycle only: wr_dim_en=1, wr_r=tr_r_q, wr_c=tr_c_q.
- DONE, 1 cycle: tr_en=0, done=1, busy=1. Next state IDLE.
- Latency:
  - start sampled in cycle 0; done is high in cycle 53+SETTLE_CYC (55 at default).
  - Minimum tr_en low time between operations: 2 cycles (DONE plus IDLE).
- start while busy: ignored, not queued; the in-flight operation is unaffected.
- src_id equal to dst_id is legal. The source is fully buffered before any write, so an in-place transpose is correct.
- Counters: rd_idx and wr_idx are 5-bit and stop at 24, never wrap.
- SETTLE counter width: 4 bits.
- rd_en and wr_en are never high in the same cycle.

Test Plan:
- Reset:
  - Stimulus: rst_n=0, then release.
  - Required: all outputs 0, busy=0.
  - Then a 3x4 start with src=1, dst=2 and storage[k]=k+1.
  - Required: wr_r=4 and wr_c=3 on wr_dim_en; wr_data at idx 5*j+i equals the source element at idx 5*i+j (e.g. wr_idx1 = 6, wr_idx5 = 2); done at cycle 55.
- Illegal dimensions:
  - start with r_in=0, then with c_in=6 -> err pulse 1 cycle each; no rd_en, wr_en or tr_en activity; busy stays 0.
- start while busy: second start at LOAD cycle 10 -> ignored; exactly 25 reads, 25 writes and 1 done.
- Back-to-back operations:
  - Two 5x5 operations with start issued in the cycle after done.
  - Required: tr_en low for at least 2 cycles between them; second result correct (an identity matrix stays identity; values 0..24 transpose correctly).
- Mid-operation reset: assert rst_n=0 during STORE idx 12 -> outputs 0 asynchronously, tr_en=0, no writes after reset, IDLE on release.
- Parameters and in-place: SETTLE_CYC=5 with src=dst=3, 2x5 -> done at cycle 58; dst holds a 5x2 transpose; tr_data stable throughout tr_en high.
